mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Arbiter and sequencer for the single shared memory port used by the IF stage (instruction fetch) and the MEM stage (load/store).
- Grants one requester at a time and holds the bus transaction stable until the memory acknowledges.
- Returns read data and a one-cycle ack to the owner, and drives stall signals consumed by the hazard logic (IF_PCWr / IF_IDWr / EXEMEM hold).
- MEM has priority; a starvation counter guarantees IF progress.

Parameters:
- IF_STARVE_MAX, 4: consecutive MEM grants allowed while if_req is pending before IF is forced ahead. Range 1-15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack or if_cancel
- if_addr  in  32  fetch address (word access, read only)
- if_cancel  in  1  redirect or flush; abandons the current or pending fetch
- if_ack  out  1  one-cycle pulse; if_rdata is valid
- if_rdata  out  32  fetched instruction
- if_stall  out  1  if_req & ~if_ack
- mem_req  in  1  load/store request; held high until mem_ack
- mem_wr  in  1  1 = store, 0 = load
- mem_addr  in  32  data address
- mem_size  in  2  00 byte, 01 half, 10 word (StoreType/LoadType size encoding)
- mem_wdata  in  32  store data
- mem_ack  out  1  one-cycle pulse; mem_rdata is valid for loads
- mem_rdata  out  32  raw load word
- mem_stall  out  1  mem_req & ~mem_ack
- bus_req  out  1  registered; high for the whole transaction
- bus_wr  out  1  registered, latched at grant
- bus_addr  out  32  registered, latched at grant
- bus_size  out  2  registered, latched at grant; 10 for fetches
- bus_wdata  out  32  registered, latched at grant; 0 for fetches
- bus_ack  in  1  one-cycle completion from memory; may arrive in the first bus_req cycle
- bus_rdata  in  32  valid when bus_ack = 1

Behaviour:
- Reset: state IDLE, starve_cnt = 0, and every bus_* output is 0. if_ack, mem_ack, if_rdata and mem_rdata are 0. Stalls follow their equations, so they equal the request inputs.
- States: IDLE, BUSY_IF, BUSY_MEM, DRAIN_IF.
- IDLE, arbitration on sampled requests:
  - Force IF when if_req & ~if_cancel & (starve_cnt == IF_STARVE_MAX); go to BUSY_IF.
  - Otherwise mem_req wins; go to BUSY_MEM.
  - Otherwise if_req & ~if_cancel; go to BUSY_IF.
  - Otherwise stay in IDLE.
- On grant, the bus_* registers latch the requester's fields and bus_req = 1 from the next cycle.
- starve_cnt:
  - increments (saturating) on each MEM grant made while if_req & ~if_cancel;
  - clears on any IF grant;
  - clears when if_req is low.
- BUSY_MEM:
  - bus_req held with fields frozen; input changes are ignored.
  - On bus_ack: mem_ack = 1 combinationally, mem_rdata = bus_rdata, bus_req cleared at the edge, next state IDLE.
  - if_cancel has no effect in this state.
- BUSY_IF, bus_ack & ~if_cancel in the same cycle: if_ack = 1, if_rdata = bus_rdata, then IDLE.
- BUSY_IF, if_cancel without bus_ack: next state DRAIN_IF with bus_req still held. No if_ack is ever produced for this transaction.
- BUSY_IF, bus_ack and if_cancel together: data discarded, no if_ack, then IDLE.
- DRAIN_IF:
  - bus_req held until bus_ack; the ack is swallowed, then IDLE.
  - if_stall is still computed from if_req; a new fetch must wait for IDLE.
- Latency:
  - Grant sampled at cycle N; bus_req is high at N+1.
  - The earliest requester ack is at N+1 (zero-wait memory).
  - IDLE is always re-entered for 1 cycle between transactions, so a back-to-back stream peaks at one transaction per 2 cycles.
- if_rdata / mem_rdata are combinational pass-throughs of bus_rdata, gated to 0 when the matching ack is low.
- Alignment and exceptions are handled upstream; the arbiter forwards mem_size unchanged, including the reserved value 11.
- Asynchronous reset mid-transaction returns to IDLE immediately, drops bus_req and produces no ack. The memory side must tolerate an abandoned request.

Test Plan:
- Reset, then if_req with if_addr = 0xBFC00000 and 2-cycle memory: bus_req at cycle 1 with bus_addr = 0xBFC00000, bus_size = 10. bus_ack at cycle 2 with bus_rdata = 0x3C1D8000 gives if_ack = 1 and if_rdata = 0x3C1D8000. if_stall is high in cycles 0-1 and low in cycle 2.
- if_req and mem_req (store, addr 0x80000010, size 01, wdata 0x0000BEEF) rise together: MEM is granted first (bus_wr = 1, bus_size = 01). IF is granted only after mem_ack plus the 1 IDLE cycle.
- if_req held high and mem_req re-raised immediately after every mem_ack, IF_STARVE_MAX = 4: exactly 4 MEM transactions, then an IF grant, and starve_cnt reads 0 afterwards.
- if_cancel pulsed in the 2nd cycle of a fetch with a 4-cycle memory: bus_req stays high through bus_ack, if_ack never asserts, state returns to IDLE. A new if_req to 0x80000100 is then granted normally.
- Zero-wait memory (bus_ack in the first bus_req cycle), load with mem_size = 00: mem_ack is seen 1 cycle after mem_req is sampled and mem_rdata = bus_rdata. bus_addr stays stable while mem_addr is toggled during BUSY_MEM.
- rst asserted during BUSY_MEM: bus_req = 0 immediately (asynchronous), no mem_ack, state IDLE. After rst deasserts, the held mem_req is re-granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one shared memory port, two requesters.
// The IF stage fetches and the MEM stage loads/stores. MEM has priority.
// A starvation counter forces a fetch after IF_STARVE_MAX consecutive MEM
// grants made while a fetch was waiting.
//
// Handshake semantics (requester side and bus side):
//   A requester raises *_req with its fields and keeps both stable until it
//   sees the matching one-cycle *_ack pulse. IF may also abandon its request
//   with if_cancel. The arbiter samples requests only in IDLE. On grant it
//   latches the fields into bus_* registers and holds bus_req high, with the
//   fields frozen, until the one-cycle bus_ack. bus_ack may arrive in the
//   first bus_req cycle. IDLE is always re-entered for one cycle between
//   transactions.
module mem_port_arbiter #(
  parameter int unsigned IF_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  // load/store port
  input  logic        mem_req,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_wdata,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  // shared memory bus
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  // debug visibility of internal state
  output logic [1:0]  dbg_state_o,
  output logic [3:0]  dbg_starve_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    DRAIN_IF = 2'd3
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(IF_STARVE_MAX);
  localparam logic [1:0] SIZE_WORD  = 2'b10;

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_wr_q, bus_wr_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [1:0]  bus_size_q, bus_size_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  logic        if_pend;

  // A fetch only competes for the port when it has not been cancelled.
  assign if_pend = if_req & ~if_cancel;

  // State, counter and bus field registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_size_q   <= 2'b00;
      bus_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_addr_q   <= bus_addr_d;
      bus_size_q   <= bus_size_d;
      bus_wdata_q  <= bus_wdata_d;
    end
  end

  // Arbitration, grant latching, completion and starvation bookkeeping.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_addr_d   = bus_addr_q;
    bus_size_d   = bus_size_q;
    bus_wdata_d  = bus_wdata_q;

    case (state_q)
      IDLE: begin
        if (if_pend && (starve_cnt_q == STARVE_MAX)) begin
          // fetch has waited long enough: it goes ahead of MEM
          state_d      = BUSY_IF;
          bus_req_d    = 1'b1;
          bus_wr_d     = 1'b0;
          bus_addr_d   = if_addr;
          bus_size_d   = SIZE_WORD;
          bus_wdata_d  = 32'd0;
          starve_cnt_d = 4'd0;
        end else if (mem_req) begin
          state_d     = BUSY_MEM;
          bus_req_d   = 1'b1;
          bus_wr_d    = mem_wr;
          bus_addr_d  = mem_addr;
          bus_size_d  = mem_size;
          bus_wdata_d = mem_wdata;
          if (if_pend && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (if_pend) begin
          state_d      = BUSY_IF;
          bus_req_d    = 1'b1;
          bus_wr_d     = 1'b0;
          bus_addr_d   = if_addr;
          bus_size_d   = SIZE_WORD;
          bus_wdata_d  = 32'd0;
          starve_cnt_d = 4'd0;
        end
      end
      BUSY_IF: begin
        if (bus_ack) begin
          // with if_cancel also high the data is simply dropped
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end else if (if_cancel) begin
          // memory still owes us an ack; wait it out without reporting it
          state_d = DRAIN_IF;
        end
      end
      BUSY_MEM: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      DRAIN_IF: begin
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase

    // a fetch that is no longer requested has nothing to be starved of
    if (!if_req) begin
      starve_cnt_d = 4'd0;
    end
  end

  // Requester-side acks and data are combinational views of the bus response.
  assign if_ack    = (state_q == BUSY_IF) & bus_ack & ~if_cancel;
  assign mem_ack   = (state_q == BUSY_MEM) & bus_ack;
  assign if_rdata  = if_ack  ? bus_rdata : 32'd0;
  assign mem_rdata = mem_ack ? bus_rdata : 32'd0;
  assign if_stall  = if_req  & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

  assign bus_req   = bus_req_q;
  assign bus_wr    = bus_wr_q;
  assign bus_addr  = bus_addr_q;
  assign bus_size  = bus_size_q;
  assign bus_wdata = bus_wdata_q;

  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = starve_cnt_q;

endmodule
